// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM state encoding
// and the owner encoding used to route completions back to IF or MEM.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Which requester owns the port in a given busy state.
  function automatic logic owner_of(input arb_state_t s);
    return (s == DATA) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// slave  : the arbiter's view (takes requests, drives memory).
// master : the environment's view (pipeline stages plus memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;
  logic              i_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_err;

  modport slave (
    input  i_req, i_addr,
    output i_rdata, i_valid, i_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_valid, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output mem_err
  );

  modport master (
    output i_req, i_addr,
    input  i_rdata, i_valid, i_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_valid, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  mem_err
  );

endinterface

// File: rtl/mem_port_arbiter_wdog.sv
// Wait-state watchdog for the memory port. Only built when MEM_TIMEOUT_EN
// is defined; otherwise this file contributes nothing.
// Counts busy cycles in which memory has not answered; expire_o fires on
// the wait cycle that brings the count up to TIMEOUT.
`ifdef MEM_TIMEOUT_EN
module mem_arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire_o = inc_i & (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next count: a new grant restarts the count; it saturates at expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-ported unified memory between the fetch
// stage (IF) and the memory stage (MEM). Data accesses win over fetches,
// a granted access is never pre-empted, and a completion can hand the
// port straight to the other pending requester without an idle cycle.
// Optional: define MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT
// cycles for mem_ready and raise the sticky mem_err flag.
//
// state | meaning
// ------+---------------------------------
// IDLE  | no access outstanding
// DATA  | data access owns the memory port
// FETCH | fetch owns the memory port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  arb_state_t        state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_valid_q;
  logic              d_valid_q;
  logic              mem_err_q;

  logic              owner;
  logic              abort;
  logic              done;
  logic              rearb;
  logic              d_pend;
  logic              i_pend;

  assign owner = owner_of(state_q);
  assign done  = mem_req_q & (bus.mem_ready | abort);
  assign rearb = (state_q == IDLE) | done;

  // A requester still shows req during its valid cycle and during the
  // completion edge itself; neither counts as a new request.
  assign d_pend = bus.d_req & ~d_valid_q & ~(done & (owner == OWN_D));
  assign i_pend = bus.i_req & ~i_valid_q & ~(done & (owner == OWN_I));

`ifdef MEM_TIMEOUT_EN
  logic grant;
  logic wd_expire;

  assign grant = rearb & (d_pend | i_pend);

  mem_arb_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (grant),
    .inc_i    (mem_req_q & ~bus.mem_ready),
    .expire_o (wd_expire)
  );

  assign abort = wd_expire;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT > 0);
  assign abort          = 1'b0;
`endif

  // Arbitration FSM: completes the current access, then regrants the port
  // to the highest-priority pending requester in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;

      if (done) begin
        if (owner == OWN_D) begin
          d_valid_q <= 1'b1;
          if (abort) begin
            d_rdata_q <= '0;
          end else if (!mem_we_q) begin
            d_rdata_q <= bus.mem_rdata;
          end
        end else begin
          i_valid_q <= 1'b1;
          i_rdata_q <= abort ? '0 : bus.mem_rdata;
        end
        if (abort) begin
          mem_err_q <= 1'b1;
        end
      end

      if (rearb) begin
        if (d_pend) begin
          state_q     <= DATA;
          mem_req_q   <= 1'b1;
          mem_we_q    <= bus.d_we;
          mem_addr_q  <= bus.d_addr;
          mem_wdata_q <= bus.d_wdata;
        end else if (i_pend) begin
          state_q     <= FETCH;
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= bus.i_addr;
          mem_wdata_q <= '0;
        end else begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_err   = mem_err_q;

  assign bus.i_rdata   = i_rdata_q;
  assign bus.i_valid   = i_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;

  // Stalls follow the requests combinationally so the hazard unit sees
  // them in the same cycle the request is raised.
  assign bus.i_stall   = bus.i_req & ~i_valid_q;
  assign bus.d_stall   = bus.d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an access-level reference model
// compared every cycle, plus literal expectations at key cycles.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (access level) ----------------
  // m_busy/m_* describe the access currently holding the port.
  logic          m_busy  = 1'b0;
  logic          m_is_d  = 1'b0;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          e_iv    = 1'b0;
  logic          e_dv    = 1'b0;
  logic [DW-1:0] e_ird   = '0;
  logic [DW-1:0] e_drd   = '0;
  logic          e_err   = 1'b0;

  logic m_abort, m_fin, d_new, i_new;

`ifdef MEM_TIMEOUT_EN
  int m_wait = 0;
  assign m_abort = m_busy && !bus.mem_ready && (m_wait == TO - 1);
`else
  assign m_abort = 1'b0;
`endif

  assign m_fin = m_busy && (bus.mem_ready || m_abort);
  assign d_new = bus.d_req && !e_dv && !(m_fin && m_is_d);
  assign i_new = bus.i_req && !e_iv && !(m_fin && !m_is_d);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_is_d <= 1'b0; m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
      e_iv <= 1'b0; e_dv <= 1'b0; e_ird <= '0; e_drd <= '0; e_err <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      m_wait <= 0;
`endif
    end else begin
      e_dv <= m_fin && m_is_d;
      e_iv <= m_fin && !m_is_d;
      if (m_fin && m_is_d && m_abort) e_drd <= '0;
      else if (m_fin && m_is_d && !m_we) e_drd <= bus.mem_rdata;
      if (m_fin && !m_is_d) e_ird <= m_abort ? '0 : bus.mem_rdata;
      if (m_abort) e_err <= 1'b1;
`ifdef MEM_TIMEOUT_EN
      if (m_busy && !bus.mem_ready) m_wait <= m_wait + 1;
`endif
      if (!m_busy || m_fin) begin
        m_busy <= d_new || i_new;
`ifdef MEM_TIMEOUT_EN
        m_wait <= 0;
`endif
        if (d_new) begin
          m_is_d <= 1'b1; m_we <= bus.d_we; m_addr <= bus.d_addr; m_wdata <= bus.d_wdata;
        end else if (i_new) begin
          m_is_d <= 1'b0; m_we <= 1'b0; m_addr <= bus.i_addr; m_wdata <= '0;
        end
      end
    end
  end

  // Per-cycle compare against the model, mid low phase.
  always begin
    @(negedge clk);
    #2;
    check("mem_req", bus.mem_req, m_busy);
    if (m_busy) begin
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_we", bus.mem_we, m_we);
      check("mem_wdata", bus.mem_wdata, m_wdata);
    end
    check("i_valid", bus.i_valid, e_iv);
    check("d_valid", bus.d_valid, e_dv);
    check("i_rdata", bus.i_rdata, e_ird);
    check("d_rdata", bus.d_rdata, e_drd);
    check("i_stall", bus.i_stall, bus.i_req & ~e_iv);
    check("d_stall", bus.d_stall, bus.d_req & ~e_dv);
    check("mem_err", bus.mem_err, e_err);
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no_finish expected finish");
    $fatal(1, "bench time limit");
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;
    rst_n = 0;
    cyc(); cyc();

    // reset state
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_i_valid", bus.i_valid, 0);
    check("rst_d_valid", bus.d_valid, 0);
    check("rst_i_rdata", bus.i_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_mem_err", bus.mem_err, 0);
    rst_n = 1;
    cyc();

    // single fetch, memory always ready
    bus.i_req = 1; bus.i_addr = 32'h10; bus.mem_ready = 1; bus.mem_rdata = 32'hE3A01005;
    #1 check("sf_stall_c0", bus.i_stall, 1);
    cyc();
    check("sf_mem_req_c1", bus.mem_req, 1);
    check("sf_mem_addr_c1", bus.mem_addr, 32'h10);
    check("sf_stall_c1", bus.i_stall, 1);
    cyc();
    check("sf_i_valid_c2", bus.i_valid, 1);
    check("sf_i_rdata_c2", bus.i_rdata, 32'hE3A01005);
    check("sf_stall_c2", bus.i_stall, 0);
    bus.i_req = 0;
    cyc();
    check("sf_i_valid_c3", bus.i_valid, 0);

    // contention: data first, fetch back-to-back
    bus.i_req = 1; bus.i_addr = 32'h40;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100; bus.mem_rdata = 32'hAA;
    cyc();
    check("ct_mem_addr_d", bus.mem_addr, 32'h100);
    check("ct_mem_req_d", bus.mem_req, 1);
    cyc();
    check("ct_d_valid", bus.d_valid, 1);
    check("ct_d_rdata", bus.d_rdata, 32'hAA);
    check("ct_mem_req_gap", bus.mem_req, 1);
    check("ct_mem_addr_i", bus.mem_addr, 32'h40);
    bus.d_req = 0; bus.mem_rdata = 32'hBB;
    cyc();
    check("ct_i_valid", bus.i_valid, 1);
    check("ct_i_rdata", bus.i_rdata, 32'hBB);
    check("ct_mem_req_end", bus.mem_req, 0);
    bus.i_req = 0;
    cyc();

    // store with three wait states
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h55; bus.mem_ready = 0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("st_mem_req", bus.mem_req, 1);
      check("st_mem_we", bus.mem_we, 1);
      check("st_mem_addr", bus.mem_addr, 32'h20);
      check("st_mem_wdata", bus.mem_wdata, 32'h55);
      check("st_d_valid_wait", bus.d_valid, 0);
      if (k == 1) bus.d_wdata = 32'h99;
      if (k == 4) bus.mem_ready = 1;
    end
    cyc();
    check("st_d_valid", bus.d_valid, 1);
    check("st_d_rdata_held", bus.d_rdata, 32'hAA);
    bus.d_req = 0; bus.d_we = 0;
    cyc();
    check("st_d_valid_once", bus.d_valid, 0);

    // data arrives during a fetch: no pre-emption
    bus.i_req = 1; bus.i_addr = 32'h80; bus.mem_ready = 0; bus.mem_rdata = 32'h11;
    cyc();
    check("np_fetch_addr1", bus.mem_addr, 32'h80);
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
    cyc();
    check("np_fetch_addr2", bus.mem_addr, 32'h80);
    check("np_fetch_we", bus.mem_we, 0);
    bus.mem_ready = 1;
    cyc();
    check("np_i_valid", bus.i_valid, 1);
    check("np_i_rdata", bus.i_rdata, 32'h11);
    check("np_data_addr", bus.mem_addr, 32'h200);
    bus.i_req = 0; bus.mem_rdata = 32'h22;
    cyc();
    check("np_d_valid", bus.d_valid, 1);
    check("np_d_rdata", bus.d_rdata, 32'h22);
    bus.d_req = 0;
    cyc();

`ifdef MEM_TIMEOUT_EN
    // timeout: memory never answers
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h60; bus.mem_ready = 0; bus.mem_rdata = 32'hDEAD;
    for (int k = 1; k <= TO; k++) begin
      cyc();
      check("to_mem_req_wait", bus.mem_req, 1);
      check("to_err_wait", bus.mem_err, 0);
    end
    cyc();
    check("to_mem_req_abort", bus.mem_req, 0);
    check("to_d_valid", bus.d_valid, 1);
    check("to_d_rdata", bus.d_rdata, 0);
    check("to_err", bus.mem_err, 1);
    bus.d_req = 0;
    cyc();
    check("to_err_sticky", bus.mem_err, 1);
    check("to_d_valid_once", bus.d_valid, 0);
    bus.mem_ready = 1;
    cyc();
`else
    check("noto_err", bus.mem_err, 0);
`endif

    // reset in the middle of a data wait
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h30; bus.mem_ready = 0;
    cyc();
    check("rm_mem_req", bus.mem_req, 1);
    cyc();
    rst_n = 0;
    #1;
    check("rm_mem_req_rst", bus.mem_req, 0);
    check("rm_d_valid_rst", bus.d_valid, 0);
    check("rm_d_rdata_rst", bus.d_rdata, 0);
    check("rm_err_rst", bus.mem_err, 0);
    bus.d_req = 0;
    cyc();
    rst_n = 1;
    cyc();
    check("rm_mem_req_after", bus.mem_req, 0);
    check("rm_d_valid_after", bus.d_valid, 0);
    bus.i_req = 1; bus.i_addr = 32'h44; bus.mem_ready = 1; bus.mem_rdata = 32'h1234;
    cyc();
    check("rm_fetch_req", bus.mem_req, 1);
    check("rm_fetch_addr", bus.mem_addr, 32'h44);
    cyc();
    check("rm_i_valid", bus.i_valid, 1);
    check("rm_i_rdata", bus.i_rdata, 32'h1234);
    bus.i_req = 0;
    cyc(); cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the fetch stage (IF) and the memory stage (MEM) of the pipelined CPU.
- Sequences each access with a registered request/ready handshake toward the memory.
- Returns read data to the winning requester and drives stall signals back to the hazard logic.
- Data accesses have fixed priority over fetches.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.
- TIMEOUT, 255, max cycles to wait for mem_ready (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high until i_valid.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched instruction.
- i_valid  out  1  one-cycle pulse: fetch complete.
- i_stall  out  1  i_req & ~i_valid.
- d_req  in  1  data request; held high until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- d_valid  out  1  one-cycle pulse: data access complete.
- d_stall  out  1  d_req & ~d_valid.
- mem_req  out  1  memory access request (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready.
- mem_ready  in  1  memory completes the access in this cycle.
- mem_err  out  1  sticky timeout flag; always 0 without MEM_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n = 0): state IDLE. All outputs are 0, including i_rdata and d_rdata. The reset takes effect immediately, even mid-access. Any access in flight is dropped with no valid pulse. Requesters re-issue after reset.
- States:
  - IDLE: no access outstanding.
  - DATA: data access owns the port.
  - FETCH: fetch owns the port.
- Transitions from IDLE, evaluated at each rising edge:
  - d_req = 1 (excluding the completion cycle, see below) -> DATA.
  - else i_req = 1 -> FETCH.
  - else stay in IDLE.
- Grant:
  - On entering DATA or FETCH, register mem_req = 1, and register mem_addr, mem_we and mem_wdata from the winner. For FETCH, mem_we = 0 and mem_wdata = 0.
  - These outputs stay stable until completion, independent of requester inputs.
- Completion: at an edge where mem_req & mem_ready:
  - Load or fetch: capture mem_rdata into d_rdata or i_rdata.
  - Pulse d_valid or i_valid for exactly the next cycle.
  - Store: d_valid pulses and d_rdata holds its previous value.
  - In the same edge, arbitrate again among pending requests. Exclude the requester just completed, since its req is still high during its valid cycle.
  - If another request is pending, go directly to its busy state with mem_req kept at 1 (back-to-back, no idle bubble). Otherwise return to IDLE with mem_req = 0.
- Latency: with mem_ready tied high, completion is 2 cycles after req first seen (req edge -> mem_req cycle -> valid cycle). Each wait cycle of mem_ready = 0 adds one cycle.
- Simultaneous i_req and d_req: data wins; the fetch is served right after the data completion. A data request arriving during a FETCH waits for that fetch to complete; there is no pre-emption.
- Rdata registers keep their last value between accesses.
- Requester dropping req before its valid: protocol violation. Any in-flight memory access is still completed and its valid is still pulsed.
- Stalls are combinational from req and valid; they have no registered delay.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on each grant and increments every busy cycle with mem_ready = 0.
  - When it reaches TIMEOUT, abort: mem_req = 0, mem_err = 1 (sticky until reset), pulse the owner's valid with rdata = 0, then go to IDLE or the next grant.
- Undefined: no counter, waits forever, mem_err tied to 0.

Decomposition:
- Package mem_arb_pkg holds:
  - enum arb_state_t {IDLE, DATA, FETCH}, 2-bit encoding;
  - localparam for the owner encoding (OWN_I = 0, OWN_D = 1).
- One natural sub-module: mem_arb_wdog (timeout counter with clear/inc/expire), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Reset mid-access:
  - Stimulus: assert rst_n = 0 during a DATA wait.
  - Required: mem_req = 0 immediately; no valid pulse; state IDLE after release; i_req then served normally.
- Single fetch:
  - Stimulus: i_req = 1, i_addr = 0x10, mem_ready tied 1, mem_rdata = 0xE3A01005.
  - Required: mem_req = 1 with mem_addr = 0x10 in cycle 1; i_valid = 1 and i_rdata = 0xE3A01005 in cycle 2; i_stall = 1 in cycles 0–1.
- Contention:
  - Stimulus: i_req and d_req both rise together (load, d_addr = 0x100); memory returns 0xAA in the data cycle and 0xBB in the fetch cycle.
  - Required: DATA granted first; d_valid with d_rdata = 0xAA; then FETCH back-to-back with no mem_req gap; i_valid with i_rdata = 0xBB.
- Store with wait states:
  - Stimulus: d_we = 1, d_addr = 0x20, d_wdata = 0x55; mem_ready low for 3 cycles.
  - Required: mem_we/addr/wdata stable for 4 cycles; d_valid pulses once; d_rdata unchanged.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT = 4):
  - Stimulus: mem_ready stuck low.
  - Required: abort after 4 wait cycles; mem_err = 1 sticky; d_valid with d_rdata = 0.
